// File: rtl/dspm_req_splitter_if.sv
// Shared request/response types and the bundled port interface between the
// load/store unit ports, the splitter and the SPM controller.

package dspm_pkg;

    localparam int unsigned INDEX_W = 12;
    localparam int unsigned TAG_W   = 44;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = DATA_W / 8;

    typedef struct packed {
        logic [INDEX_W-1:0] address_index;
        logic [TAG_W-1:0]   address_tag;
        logic [DATA_W-1:0]  data_wdata;
        logic [BE_W-1:0]    data_be;
        logic               data_we;
        logic               data_req;
        logic               tag_valid;
        logic               kill_req;
    } dcache_req_i_t;

    typedef struct packed {
        logic               data_gnt;
        logic               data_rvalid;
        logic [DATA_W-1:0]  data_rdata;
    } dcache_req_o_t;

endpackage

interface dspm_req_splitter_if
    import dspm_pkg::*;
#(
    parameter int unsigned NR_PORTS = 3
);

    dcache_req_i_t [NR_PORTS-1:0] req_ports_i;
    dcache_req_o_t [NR_PORTS-1:0] req_ports_o;
    dcache_req_i_t [NR_PORTS-1:0] spm_req_ports_o;
    dcache_req_o_t [NR_PORTS-1:0] spm_req_ports_i;

    // Splitter side: takes upstream requests and controller responses.
    modport slave (
        input  req_ports_i,
        output req_ports_o,
        output spm_req_ports_o,
        input  spm_req_ports_i
    );

    // Environment side: the load/store unit and the SPM controller together.
    modport master (
        output req_ports_i,
        input  req_ports_o,
        input  spm_req_ports_o,
        output spm_req_ports_i
    );

endinterface

// File: rtl/dspm_req_splitter.sv
// Turns the two-phase load / single-phase store protocol of each LSU port into
// a held, single-phase combined request for the SPM controller, and routes the
// controller response back upstream. One independent FSM per port.

module dspm_req_splitter
    import dspm_pkg::*;
#(
    parameter int unsigned NR_PORTS = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    dspm_req_splitter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TAG,
        RD_REQ,
        WR_REQ,
        RESP
    } state_e;

    for (genvar g = 0; g < NR_PORTS; g++) begin : gen_port

        state_e             r_state;
        state_e             w_next;
        logic [INDEX_W-1:0] r_index;
        logic [TAG_W-1:0]   r_tag;
        logic [DATA_W-1:0]  r_wdata;
        logic [BE_W-1:0]    r_be;
        logic               r_we;
        logic               r_killed;
        logic [DATA_W-1:0]  r_rdata;

        dcache_req_i_t      w_up_req;
        dcache_req_o_t      w_up_rsp;
        dcache_req_i_t      w_spm_req;
        dcache_req_o_t      w_spm_rsp;

        assign w_up_req               = bus.req_ports_i[g];
        assign w_spm_rsp              = bus.spm_req_ports_i[g];
        assign bus.req_ports_o[g]     = w_up_rsp;
        assign bus.spm_req_ports_o[g] = w_spm_req;

        // State register; an asynchronous reset drops any outstanding request at once.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        // Capture request fields on accept, the tag on tag_valid, and read data / kill status while reading.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_index  <= '0;
                r_tag    <= '0;
                r_wdata  <= '0;
                r_be     <= '0;
                r_we     <= 1'b0;
                r_killed <= 1'b0;
                r_rdata  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_up_req.data_req) begin
                            r_index <= w_up_req.address_index;
                            r_we    <= w_up_req.data_we;
                            if (w_up_req.data_we) begin
                                r_tag   <= w_up_req.address_tag;
                                r_wdata <= w_up_req.data_wdata;
                                r_be    <= w_up_req.data_be;
                            end
                        end
                    end
                    WAIT_TAG: begin
                        if (!w_up_req.kill_req && w_up_req.tag_valid) begin
                            r_tag <= w_up_req.address_tag;
                        end
                    end
                    RD_REQ: begin
                        if (w_spm_rsp.data_rvalid) begin
                            r_killed <= 1'b0;
                            if (!(r_killed || w_up_req.kill_req)) begin
                                r_rdata <= w_spm_rsp.data_rdata;
                            end
                        end else if (w_up_req.kill_req) begin
                            r_killed <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Next state plus both response and request outputs; only the upstream grant looks at live inputs.
        always_comb begin
            w_next    = r_state;
            w_up_rsp  = '0;
            w_spm_req = '0;
            case (r_state)
                IDLE: begin
                    if (w_up_req.data_req) begin
                        w_up_rsp.data_gnt = 1'b1;
                        w_next = w_up_req.data_we ? WR_REQ : WAIT_TAG;
                    end
                end
                WAIT_TAG: begin
                    if (w_up_req.kill_req) begin
                        w_next = IDLE;
                    end else if (w_up_req.tag_valid) begin
                        w_next = RD_REQ;
                    end
                end
                RD_REQ: begin
                    w_spm_req.data_req      = 1'b1;
                    w_spm_req.data_we       = r_we;
                    w_spm_req.data_be       = '1;
                    w_spm_req.address_index = r_index;
                    w_spm_req.address_tag   = r_tag;
                    if (w_spm_rsp.data_rvalid) begin
                        w_next = (r_killed || w_up_req.kill_req) ? IDLE : RESP;
                    end
                end
                WR_REQ: begin
                    w_spm_req.data_req      = 1'b1;
                    w_spm_req.data_we       = r_we;
                    w_spm_req.data_be       = r_be;
                    w_spm_req.data_wdata    = r_wdata;
                    w_spm_req.address_index = r_index;
                    w_spm_req.address_tag   = r_tag;
                    if (w_spm_rsp.data_gnt) begin
                        w_next = IDLE;
                    end
                end
                RESP: begin
                    w_up_rsp.data_rvalid = 1'b1;
                    w_up_rsp.data_rdata  = r_rdata;
                    w_next = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end

    end

endmodule

// File: tb/tb_dspm_req_splitter.sv
// Directed bench for dspm_req_splitter: store, load, kills, two-port contention
// and reset in the middle of a read, with hand-computed expectations.

module tb_dspm_req_splitter;
    import dspm_pkg::*;

    logic clk_i;
    logic rst_ni;
    int   vectors;
    int   miscompares;

    dspm_req_splitter_if #(.NR_PORTS(3)) bus ();

    dspm_req_splitter #(.NR_PORTS(3)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkReq(input string tag, input dcache_req_i_t obs, input dcache_req_i_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResp(input string tag, input dcache_req_o_t obs, input dcache_req_o_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected combined downstream request.
    function automatic dcache_req_i_t mkDown(input logic we, input logic [11:0] idx,
                                             input logic [43:0] tag, input logic [63:0] wd,
                                             input logic [7:0] be);
        dcache_req_i_t r;
        r               = '0;
        r.data_req      = 1'b1;
        r.data_we       = we;
        r.address_index = idx;
        r.address_tag   = tag;
        r.data_wdata    = wd;
        r.data_be       = be;
        return r;
    endfunction

    // Upstream request used to start a load or store.
    function automatic dcache_req_i_t mkUp(input logic we, input logic [11:0] idx,
                                           input logic [43:0] tag, input logic [63:0] wd,
                                           input logic [7:0] be);
        dcache_req_i_t r;
        r               = '0;
        r.data_req      = 1'b1;
        r.data_we       = we;
        r.address_index = idx;
        r.address_tag   = tag;
        r.data_wdata    = wd;
        r.data_be       = be;
        return r;
    endfunction

    // Upstream tag / kill phase of a load.
    function automatic dcache_req_i_t mkTag(input logic tv, input logic kill, input logic [43:0] tag);
        dcache_req_i_t r;
        r             = '0;
        r.tag_valid   = tv;
        r.kill_req    = kill;
        r.address_tag = tag;
        return r;
    endfunction

    // The directed sequence.
    initial begin
        dcache_req_i_t expSt;
        dcache_req_i_t expLd;
        dcache_req_i_t expP0;
        dcache_req_i_t expP2;

        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        bus.req_ports_i     = '0;
        bus.spm_req_ports_i = '0;

        // ---------------- reset state
        repeat (2) @(posedge clk_i);
        #2;
        for (int p = 0; p < 3; p++) begin
            checkResp($sformatf("rst_up%0d", p), bus.req_ports_o[p], '0);
            checkReq($sformatf("rst_spm%0d", p), bus.spm_req_ports_o[p], '0);
        end
        rst_ni = 1'b1;
        nextCycle();

        // ---------------- store on port 0, one controller wait stage
        expSt = mkDown(1'b1, 12'h048, 44'h1, 64'hDEADBEEF_00112233, 8'hFF);
        bus.req_ports_i[0] = mkUp(1'b1, 12'h048, 44'h1, 64'hDEADBEEF_00112233, 8'hFF);
        #1;
        checkBit("st_c0_gnt", bus.req_ports_o[0].data_gnt, 1'b1);
        checkBit("st_c0_spmreq", bus.spm_req_ports_o[0].data_req, 1'b0);
        nextCycle();
        bus.req_ports_i[0] = '0;
        #1;
        checkReq("st_c1_spm", bus.spm_req_ports_o[0], expSt);
        checkBit("st_c1_gnt", bus.req_ports_o[0].data_gnt, 1'b0);
        checkBit("st_c1_rvalid", bus.req_ports_o[0].data_rvalid, 1'b0);
        nextCycle();
        bus.spm_req_ports_i[0].data_gnt = 1'b1;
        #1;
        checkReq("st_c2_spm", bus.spm_req_ports_o[0], expSt);
        checkBit("st_c2_rvalid", bus.req_ports_o[0].data_rvalid, 1'b0);
        nextCycle();
        bus.spm_req_ports_i[0] = '0;
        #1;
        checkReq("st_c3_spm_idle", bus.spm_req_ports_o[0], '0);
        checkBit("st_c3_rvalid", bus.req_ports_o[0].data_rvalid, 1'b0);

        // ---------------- load on port 1, tag three cycles after grant
        expLd = mkDown(1'b0, 12'h010, 44'h2, 64'h0, 8'hFF);
        nextCycle();
        bus.req_ports_i[1] = mkUp(1'b0, 12'h010, 44'h0, 64'h0, 8'h00);
        #1;
        checkBit("ld_c0_gnt", bus.req_ports_o[1].data_gnt, 1'b1);
        nextCycle();
        bus.req_ports_i[1] = '0;
        #1;
        checkBit("ld_c1_noreq", bus.spm_req_ports_o[1].data_req, 1'b0);
        nextCycle();
        #1;
        checkBit("ld_c2_noreq", bus.spm_req_ports_o[1].data_req, 1'b0);
        nextCycle();
        bus.req_ports_i[1] = mkTag(1'b1, 1'b0, 44'h2);
        #1;
        checkBit("ld_c3_noreq", bus.spm_req_ports_o[1].data_req, 1'b0);
        nextCycle();
        bus.req_ports_i[1] = '0;
        #1;
        checkReq("ld_c4_spm", bus.spm_req_ports_o[1], expLd);
        checkBit("ld_c4_rvalid", bus.req_ports_o[1].data_rvalid, 1'b0);
        nextCycle();
        bus.spm_req_ports_i[1].data_rvalid = 1'b1;
        bus.spm_req_ports_i[1].data_rdata  = 64'h0123456789ABCDEF;
        #1;
        checkReq("ld_c5_spm_held", bus.spm_req_ports_o[1], expLd);
        checkBit("ld_c5_rvalid", bus.req_ports_o[1].data_rvalid, 1'b0);
        nextCycle();
        bus.spm_req_ports_i[1] = '0;
        #1;
        checkBit("ld_c6_rvalid", bus.req_ports_o[1].data_rvalid, 1'b1);
        checkOutput("ld_c6_rdata", bus.req_ports_o[1].data_rdata, 64'h0123456789ABCDEF);
        checkBit("ld_c6_spm_drop", bus.spm_req_ports_o[1].data_req, 1'b0);
        nextCycle();
        #1;
        checkBit("ld_c7_rvalid", bus.req_ports_o[1].data_rvalid, 1'b0);

        // ---------------- kill together with tag_valid in WAIT_TAG, port 2
        nextCycle();
        bus.req_ports_i[2] = mkUp(1'b0, 12'h020, 44'h0, 64'h0, 8'h00);
        #1;
        checkBit("kw_c0_gnt", bus.req_ports_o[2].data_gnt, 1'b1);
        nextCycle();
        bus.req_ports_i[2] = mkTag(1'b1, 1'b1, 44'h3);
        #1;
        checkBit("kw_c1_noreq", bus.spm_req_ports_o[2].data_req, 1'b0);
        nextCycle();
        bus.req_ports_i[2] = '0;
        #1;
        checkBit("kw_c2_noreq", bus.spm_req_ports_o[2].data_req, 1'b0);
        nextCycle();
        bus.req_ports_i[2] = mkUp(1'b0, 12'h021, 44'h0, 64'h0, 8'h00);
        #1;
        checkBit("kw_c3_regrant", bus.req_ports_o[2].data_gnt, 1'b1);
        nextCycle();
        bus.req_ports_i[2] = mkTag(1'b0, 1'b1, 44'h0);
        nextCycle();
        bus.req_ports_i[2] = '0;
        #1;
        checkBit("kw_c5_noreq", bus.spm_req_ports_o[2].data_req, 1'b0);

        // ---------------- kill while in RD_REQ, port 0
        nextCycle();
        bus.req_ports_i[0] = mkUp(1'b0, 12'h030, 44'h0, 64'h0, 8'h00);
        #1;
        checkBit("kr_c0_gnt", bus.req_ports_o[0].data_gnt, 1'b1);
        nextCycle();
        bus.req_ports_i[0] = mkTag(1'b1, 1'b0, 44'h4);
        nextCycle();
        bus.req_ports_i[0] = mkTag(1'b0, 1'b1, 44'h0);
        #1;
        checkBit("kr_c2_req", bus.spm_req_ports_o[0].data_req, 1'b1);
        nextCycle();
        bus.req_ports_i[0] = '0;
        #1;
        checkReq("kr_c3_held", bus.spm_req_ports_o[0], mkDown(1'b0, 12'h030, 44'h4, 64'h0, 8'hFF));
        nextCycle();
        bus.spm_req_ports_i[0].data_rvalid = 1'b1;
        bus.spm_req_ports_i[0].data_rdata  = 64'h0000_0000_0000_0BAD;
        #1;
        checkBit("kr_c4_req", bus.spm_req_ports_o[0].data_req, 1'b1);
        checkBit("kr_c4_rvalid", bus.req_ports_o[0].data_rvalid, 1'b0);
        nextCycle();
        bus.spm_req_ports_i[0] = '0;
        bus.req_ports_i[0] = mkUp(1'b0, 12'h031, 44'h0, 64'h0, 8'h00);
        #1;
        checkBit("kr_c5_rvalid", bus.req_ports_o[0].data_rvalid, 1'b0);
        checkBit("kr_c5_idle_gnt", bus.req_ports_o[0].data_gnt, 1'b1);
        checkBit("kr_c5_noreq", bus.spm_req_ports_o[0].data_req, 1'b0);
        nextCycle();
        bus.req_ports_i[0] = mkTag(1'b0, 1'b1, 44'h0);
        #1;
        checkBit("kr_c6_rvalid", bus.req_ports_o[0].data_rvalid, 1'b0);
        nextCycle();
        bus.req_ports_i[0] = '0;

        // ---------------- contention: ports 0 and 2 load together, port 0 served first
        expP0 = mkDown(1'b0, 12'h100, 44'h5, 64'h0, 8'hFF);
        expP2 = mkDown(1'b0, 12'h200, 44'h6, 64'h0, 8'hFF);
        nextCycle();
        bus.req_ports_i[0] = mkUp(1'b0, 12'h100, 44'h0, 64'h0, 8'h00);
        bus.req_ports_i[2] = mkUp(1'b0, 12'h200, 44'h0, 64'h0, 8'h00);
        #1;
        checkBit("ct_c0_gnt0", bus.req_ports_o[0].data_gnt, 1'b1);
        checkBit("ct_c0_gnt2", bus.req_ports_o[2].data_gnt, 1'b1);
        nextCycle();
        bus.req_ports_i[0] = mkTag(1'b1, 1'b0, 44'h5);
        bus.req_ports_i[2] = mkTag(1'b1, 1'b0, 44'h6);
        nextCycle();
        bus.req_ports_i[0] = '0;
        bus.req_ports_i[2] = '0;
        #1;
        checkReq("ct_c2_spm0", bus.spm_req_ports_o[0], expP0);
        checkReq("ct_c2_spm2", bus.spm_req_ports_o[2], expP2);
        nextCycle();
        bus.spm_req_ports_i[0].data_rvalid = 1'b1;
        bus.spm_req_ports_i[0].data_rdata  = 64'hAAAA_0000_1111_0000;
        #1;
        checkReq("ct_c3_spm2", bus.spm_req_ports_o[2], expP2);
        nextCycle();
        bus.spm_req_ports_i[0] = '0;
        #1;
        checkBit("ct_c4_rv0", bus.req_ports_o[0].data_rvalid, 1'b1);
        checkOutput("ct_c4_rd0", bus.req_ports_o[0].data_rdata, 64'hAAAA_0000_1111_0000);
        checkBit("ct_c4_rv2", bus.req_ports_o[2].data_rvalid, 1'b0);
        checkReq("ct_c4_spm2", bus.spm_req_ports_o[2], expP2);
        nextCycle();
        bus.spm_req_ports_i[2].data_rvalid = 1'b1;
        bus.spm_req_ports_i[2].data_rdata  = 64'hBBBB_2222_3333_4444;
        #1;
        checkBit("ct_c5_rv0", bus.req_ports_o[0].data_rvalid, 1'b0);
        checkReq("ct_c5_spm2", bus.spm_req_ports_o[2], expP2);
        nextCycle();
        bus.spm_req_ports_i[2] = '0;
        #1;
        checkBit("ct_c6_rv2", bus.req_ports_o[2].data_rvalid, 1'b1);
        checkOutput("ct_c6_rd2", bus.req_ports_o[2].data_rdata, 64'hBBBB_2222_3333_4444);
        checkBit("ct_c6_rv0", bus.req_ports_o[0].data_rvalid, 1'b0);
        nextCycle();

        // ---------------- reset while port 1 is in RD_REQ
        bus.req_ports_i[1] = mkUp(1'b0, 12'h055, 44'h0, 64'h0, 8'h00);
        nextCycle();
        bus.req_ports_i[1] = mkTag(1'b1, 1'b0, 44'h7);
        nextCycle();
        bus.req_ports_i[1] = '0;
        #1;
        checkBit("rs_rdreq", bus.spm_req_ports_o[1].data_req, 1'b1);
        rst_ni = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            checkResp($sformatf("rs_up%0d", p), bus.req_ports_o[p], '0);
            checkReq($sformatf("rs_spm%0d", p), bus.spm_req_ports_o[p], '0);
        end
        nextCycle();
        rst_ni = 1'b1;
        nextCycle();
        expSt = mkDown(1'b1, 12'h066, 44'h8, 64'hCAFE_F00D_1234_5678, 8'h0F);
        bus.req_ports_i[1] = mkUp(1'b1, 12'h066, 44'h8, 64'hCAFE_F00D_1234_5678, 8'h0F);
        #1;
        checkBit("rs_st_gnt", bus.req_ports_o[1].data_gnt, 1'b1);
        nextCycle();
        bus.req_ports_i[1] = '0;
        bus.spm_req_ports_i[1].data_gnt = 1'b1;
        #1;
        checkReq("rs_st_spm", bus.spm_req_ports_o[1], expSt);
        nextCycle();
        bus.spm_req_ports_i[1] = '0;
        #1;
        checkReq("rs_st_idle", bus.spm_req_ports_o[1], '0);
        checkBit("rs_st_rvalid", bus.req_ports_o[1].data_rvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dspm_req_splitter.md
# dspm_req_splitter

Front end of the D-cache scratchpad (SPM) path. Converts the two-phase CVA6 load protocol and the single-phase store protocol on each load/store port into held, single-phase combined requests (index + tag + data) for the SPM controller. Holds each request stable until the controller responds, then returns the response upstream. Sits between the load/store unit ports and the SPM controller's `spm_req_ports_i`/`spm_req_ports_o`.

## Interface
- `NR_PORTS`, 3: number of independent request ports. One FSM per port; port *i* upstream maps to port *i* downstream.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset; asynchronous, active-low.
- `req_ports_i`  in  `dcache_req_i_t [NR_PORTS]`: upstream requests. Fields used: `address_index`, `address_tag`, `data_wdata`, `data_be`, `data_we`, `data_req`, `tag_valid`, `kill_req`.
- `req_ports_o`  out  `dcache_req_o_t [NR_PORTS]`: upstream responses. Fields driven: `data_gnt`, `data_rvalid`, `data_rdata`.
- `spm_req_ports_o`  out  `dcache_req_i_t [NR_PORTS]`: combined requests to the SPM controller.
- `spm_req_ports_i`  in  `dcache_req_o_t [NR_PORTS]`: SPM controller responses. A write is answered by `data_gnt`; a read by `data_rvalid` + `data_rdata`.

## Operation
- Each port has its own FSM with states IDLE, WAIT_TAG, RD_REQ, WR_REQ, RESP. Per-port registers: index, tag, wdata, be, we, killed flag, rdata.
- **IDLE**
  - Upstream `data_req=1`, `data_we=1` (store):
    - Assert upstream `data_gnt` combinationally.
    - Register index, tag, wdata, be.
    - Next state WR_REQ.
  - Upstream `data_req=1`, `data_we=0` (load):
    - Assert upstream `data_gnt` combinationally.
    - Register index.
    - Next state WAIT_TAG.
  - `kill_req` and `tag_valid` are ignored in IDLE.
- **WAIT_TAG**
  - `kill_req=1` → IDLE. Kill wins over a simultaneous `tag_valid`.
  - `tag_valid=1` → register `address_tag`, go to RD_REQ.
  - Otherwise stay in WAIT_TAG. There is no timeout.
- **RD_REQ**
  - Drive downstream from registers only: `data_req=1`, `data_we=0`, `data_be='1`, `data_wdata=0`.
  - `kill_req=1` sets the killed flag. The request is NOT withdrawn.
  - On downstream `data_rvalid`:
    - Killed flag set (including a kill in the same cycle) → clear the flag, go to IDLE, no upstream rvalid.
    - Otherwise → register `data_rdata`, go to RESP.
- **WR_REQ**
  - Drive downstream `data_req=1`, `data_we=1`, plus registered index, tag, wdata, be.
  - On downstream `data_gnt` → IDLE.
- **RESP**
  - Upstream `data_rvalid=1`, `data_rdata` = registered data, for exactly one cycle.
  - Then go to IDLE. No grant is given in RESP.
- Downstream request fields stay constant while in RD_REQ/WR_REQ. The controller re-reads `data_we` at response time and arbitrates lower ports first, so a port may wait an unbounded number of cycles.
- Downstream `data_req` is deasserted in the cycle after the response is seen. This prevents the controller from re-issuing the request.
- Ports are fully independent. A response on port *j* never changes the state of port *i*.
- Outside RD_REQ/WR_REQ, downstream `data_req=0`.

## Timing
- Reset values:
  - All FSMs in IDLE.
  - All registers zero.
  - All `req_ports_o` fields 0.
  - All `spm_req_ports_o` fields 0.
- Reset asserted mid-operation abandons the transaction. Downstream `data_req` drops immediately (asynchronous reset). No response is produced upstream.
- Load, uncontended, controller with one wait stage, tag on the cycle after grant:
  - C0: gnt.
  - C1: tag_valid.
  - C2: downstream req.
  - C3: downstream rvalid (req still high).
  - C4: upstream rvalid.
  - C5: IDLE, new grant possible.
- Store, uncontended, one wait stage:
  - C0: gnt.
  - C1–C2: downstream req.
  - C2: downstream gnt.
  - C3: IDLE.
- Controller with zero wait stages: the response arrives in the first RD_REQ/WR_REQ cycle. That is one state-cycle each.
- Upstream gnt is purely combinational from IDLE and upstream `data_req`. Everything else is registered.

## Test plan
- **Store:** port 0 store, index 0x048, tag 0x1, wdata 0xDEADBEEF_00112233, be 0xFF.
  - Required: gnt in C0; downstream req with exactly these fields in C1–C2; IDLE in C3.
  - No upstream rvalid at any point.
- **Load:** port 1 load, index 0x010; tag 0x2 presented 3 cycles after gnt; controller returns 0x0123456789ABCDEF.
  - Required: no downstream req before the tag arrives.
  - Upstream rvalid for exactly 1 cycle, with 0x0123456789ABCDEF, the cycle after downstream rvalid.
- **Kill in WAIT_TAG:** `kill_req` together with `tag_valid` in WAIT_TAG.
  - Required: downstream req never asserted; FSM back in IDLE; next load is granted.
- **Kill in RD_REQ:** `kill_req` asserted in RD_REQ.
  - Required: downstream req held until rvalid; upstream rvalid never asserted; IDLE on the following cycle.
- **Contention:** ports 0 and 2 both issue loads in the same cycle; controller services port 0 first.
  - Required: port 2 holds req with unchanged fields until its own rvalid; each port receives only its own data.
- **Reset mid-operation:** `rst_ni` low while in RD_REQ.
  - Required: all outputs 0 immediately; after release, a store completes normally.
